// File: rtl/rgb565_to_gray.sv
// rtl/rgb565_to_gray.sv - RGB565 to 8-bit luminance, 3-stage pipeline with delayed syncs.
// Define GRAY_MEAN_EN to add the per-frame mean luminance unit (accumulator + serial divider).
module rgb565_to_gray #(
    parameter int ACC_W = 27,
    parameter int CNT_W = 19
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic [15:0] data_rgb,
    input  logic        hsync_rgb,
    input  logic        vsync_rgb,
    output logic [7:0]  data_gray,
    output logic        hsync_gray,
    output logic        vsync_gray,
    output logic [7:0]  gray_mean,
    output logic        mean_valid
);

    // The divisor must fit the compare width and a single pixel must fit the accumulator.
    if (CNT_W > ACC_W || ACC_W < 8) begin : g_param_check
        $error("rgb565_to_gray: need 8 <= ACC_W and CNT_W <= ACC_W");
    end

    logic [7:0]  r8, g8, b8;
    logic [14:0] p_r_d, p_r_q;
    logic [15:0] p_g_d, p_g_q;
    logic [12:0] p_b_d, p_b_q;
    logic [15:0] sum_d, sum_q;
    logic [2:0]  hs_q, vs_q;
    logic [7:0]  data_gray_q;

    assign r8    = {data_rgb[15:11], data_rgb[15:13]};
    assign g8    = {data_rgb[10:5],  data_rgb[10:9]};
    assign b8    = {data_rgb[4:0],   data_rgb[4:2]};
    assign p_r_d = 15'(r8) * 15'd77;
    assign p_g_d = 16'(g8) * 16'd150;
    assign p_b_d = 13'(b8) * 13'd29;
    assign sum_d = 16'(p_r_q) + p_g_q + 16'(p_b_q);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            p_r_q       <= '0;
            p_g_q       <= '0;
            p_b_q       <= '0;
            sum_q       <= '0;
            hs_q        <= '0;
            vs_q        <= '0;
            data_gray_q <= '0;
        end else begin
            p_r_q       <= p_r_d;
            p_g_q       <= p_g_d;
            p_b_q       <= p_b_d;
            sum_q       <= sum_d;
            hs_q        <= {hs_q[1:0], hsync_rgb};
            vs_q        <= {vs_q[1:0], vsync_rgb};
            data_gray_q <= hs_q[1] ? sum_q[15:8] : 8'd0;
        end
    end

    assign data_gray  = data_gray_q;
    assign hsync_gray = hs_q[2];
    assign vsync_gray = vs_q[2];

`ifdef GRAY_MEAN_EN
    localparam int CMP_W = ACC_W + 8;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, div_q;
    logic [ACC_W:0]   acc_sum;
    logic [CNT_W:0]   cnt_sum;
    logic [CMP_W-1:0] shifted;
    logic [7:0]       quo_q, quo_d, mean_q;
    logic [2:0]       iter_q;
    logic             vsync_prev_q, frame_edge, take;

    assign frame_edge = vsync_gray && !vsync_prev_q;
    assign acc_sum    = {1'b0, acc_q} + (ACC_W+1)'(data_gray);
    assign cnt_sum    = {1'b0, cnt_q} + (CNT_W+1)'(1);

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (frame_edge) begin
            // The pixel coincident with the edge opens the new frame.
            acc_d = ACC_W'(data_gray);
            cnt_d = hsync_gray ? CNT_W'(1) : '0;
        end else if (hsync_gray) begin
            acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    // take implies shifted <= rem, so truncating shifted to ACC_W bits is exact.
    assign shifted = CMP_W'(div_q) << iter_q;
    assign take    = CMP_W'(rem_q) >= shifted;
    assign rem_d   = take ? rem_q - shifted[ACC_W-1:0] : rem_q;
    assign quo_d   = quo_q | (8'(take) << iter_q);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_edge) begin
            state_d = (cnt_q != '0) ? DIV : IDLE;
        end else begin
            case (state_q)
                DIV:     if (iter_q == 3'd0) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mean_valid = (state_q == DONE) && !frame_edge;
        gray_mean  = mean_valid ? quo_q : mean_q;
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            quo_q        <= '0;
            iter_q       <= '0;
            mean_q       <= '0;
            vsync_prev_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            vsync_prev_q <= vsync_gray;
            if (frame_edge) begin
                rem_q  <= acc_q;
                div_q  <= cnt_q;
                quo_q  <= '0;
                iter_q <= 3'd7;
            end else if (state_q == DIV) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                iter_q <= iter_q - 3'd1;
            end
            if (mean_valid) begin
                mean_q <= quo_q;
            end
        end
    end
`else
    assign gray_mean  = 8'd0;
    assign mean_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rgb565_to_gray.sv
// tb/tb_rgb565_to_gray.sv - directed vector bench for rgb565_to_gray.
module tb_rgb565_to_gray;

`ifdef GRAY_MEAN_EN
    localparam bit MEAN_EN = 1'b1;
`else
    localparam bit MEAN_EN = 1'b0;
`endif

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_rgb = '0;
    logic        hsync_rgb = 1'b0;
    logic        vsync_rgb = 1'b0;
    logic [7:0]  data_gray;
    logic        hsync_gray;
    logic        vsync_gray;
    logic [7:0]  gray_mean;
    logic        mean_valid;

    rgb565_to_gray dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .data_rgb   (data_rgb),
        .hsync_rgb  (hsync_rgb),
        .vsync_rgb  (vsync_rgb),
        .data_gray  (data_gray),
        .hsync_gray (hsync_gray),
        .vsync_gray (vsync_gray),
        .gray_mean  (gray_mean),
        .mean_valid (mean_valid)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [15:0] d;
        logic        h;
        logic        v;
        logic [7:0]  g;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         pulse_cyc = -1;
    int         edge_cyc = -1;
    logic [7:0] last_mean = '0;
    logic       vs_prev_tb = 1'b0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (mean_valid) begin
            pulse_cnt = pulse_cnt + 1;
            pulse_cyc = cyc;
            last_mean = gray_mean;
        end
        if (vsync_gray && !vs_prev_tb) edge_cyc = cyc;
        vs_prev_tb = vsync_gray;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #2;
    endtask

    task automatic drive(input logic [15:0] d, input logic h, input logic v);
        data_rgb  = d;
        hsync_rgb = h;
        vsync_rgb = v;
    endtask

    task automatic idle(input int n);
        drive(16'h0000, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic pixels(input logic [15:0] d, input int n);
        repeat (n) begin
            drive(d, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic vs_pulse();
        drive(16'h0000, 1'b0, 1'b1);
        tick();
        drive(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_gray"},  int'(data_gray),  0);
        check({tag, "_hsync_gray"}, int'(hsync_gray), 0);
        check({tag, "_vsync_gray"}, int'(vsync_gray), 0);
        check({tag, "_gray_mean"},  int'(gray_mean),  0);
        check({tag, "_mean_valid"}, int'(mean_valid), 0);
    endtask

    vec_t tv[10];
    int   p0;

    initial begin
        tv[0] = '{16'hF800, 1'b1, 1'b0, 8'd76};
        tv[1] = '{16'h07E0, 1'b1, 1'b0, 8'd149};
        tv[2] = '{16'h001F, 1'b1, 1'b0, 8'd28};
        tv[3] = '{16'hFFFF, 1'b1, 1'b0, 8'd255};
        tv[4] = '{16'h0000, 1'b1, 1'b0, 8'd0};
        tv[5] = '{16'h8410, 1'b1, 1'b0, 8'd130};
        tv[6] = '{16'hFFFF, 1'b0, 1'b0, 8'd0};
        tv[7] = '{16'hFFFF, 1'b0, 1'b1, 8'd0};
        tv[8] = '{16'hFFFF, 1'b0, 1'b0, 8'd0};
        tv[9] = '{16'hFFFF, 1'b1, 1'b0, 8'd255};

        rst_n = 1'b0;
        drive(16'hFFFF, 1'b1, 1'b1);
        repeat (3) tick();
        check_all_zero("reset");
        drive(16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        for (int j = 0; j < 13; j++) begin
            tick();
            if (j >= 3) begin
                check($sformatf("vec%0d_gray", j-3),  int'(data_gray),  int'(tv[j-3].g));
                check($sformatf("vec%0d_hsync", j-3), int'(hsync_gray), int'(tv[j-3].h));
                check($sformatf("vec%0d_vsync", j-3), int'(vsync_gray), int'(tv[j-3].v));
            end
            if (j < 10) drive(tv[j].d, tv[j].h, tv[j].v);
            else        drive(16'h0000, 1'b0, 1'b0);
        end

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        idle(2);

        // empty first frame: no pulse, mean stays 0
        p0 = pulse_cnt;
        vs_pulse();
        idle(15);
        check("empty_frame_pulses", pulse_cnt - p0, 0);
        check("empty_frame_mean", int'(gray_mean), 0);

        // 4 white + 4 black -> 1020/8 = 127
        p0 = pulse_cnt;
        pixels(16'hFFFF, 4);
        pixels(16'h0000, 4);
        idle(2);
        vs_pulse();
        idle(15);
        check("half_frame_pulses", pulse_cnt - p0, MEAN_EN ? 1 : 0);
        check("half_frame_mean", int'(gray_mean), MEAN_EN ? 127 : 0);
`ifdef GRAY_MEAN_EN
        check("half_frame_latency", pulse_cyc - edge_cyc, 9);
        check("half_frame_pulse_value", int'(last_mean), 127);
`endif

        // second edge 4 cycles after the first aborts the 255 result
        p0 = pulse_cnt;
        pixels(16'hFFFF, 2);
        idle(2);
        drive(16'h8410, 1'b1, 1'b1);
        tick();
        pixels(16'h8410, 3);
        vs_pulse();
        idle(20);
        check("abort_pulses", pulse_cnt - p0, MEAN_EN ? 1 : 0);
        check("abort_mean", int'(gray_mean), MEAN_EN ? 130 : 0);
`ifdef GRAY_MEAN_EN
        check("abort_latency", pulse_cyc - edge_cyc, 9);
        check("abort_pulse_value", int'(last_mean), 130);
`endif

        // reset in the middle of a division
        p0 = pulse_cnt;
        pixels(16'hFFFF, 2);
        idle(2);
        vs_pulse();
        idle(4);
        rst_n = 1'b0;
        drive(16'hFFFF, 1'b1, 1'b0);
        tick();
        check_all_zero("mid_div_reset");
        rst_n = 1'b1;
        idle(20);
        check("post_reset_pulses", pulse_cnt - p0, 0);
        check("post_reset_mean", int'(gray_mean), 0);

        p0 = pulse_cnt;
        pixels(16'h07E0, 2);
        idle(2);
        vs_pulse();
        idle(15);
        check("new_frame_pulses", pulse_cnt - p0, MEAN_EN ? 1 : 0);
        check("new_frame_mean", int'(gray_mean), MEAN_EN ? 149 : 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
